// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and default operand width for the Booth controller
package booth_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EVAL  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/booth_counter.sv
// booth_counter: iteration counter, loads N, counts down to zero and saturates there
module booth_counter
   import booth_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: reload wins, decrement stops at zero
   always_comb begin
      zero  = cnt_q == '0;
      cnt_d = load ? CW'(N) : (dec && !zero) ? cnt_q - CW'(1) : cnt_q;
   end

   // count register, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/booth_ctrl.sv
// booth_ctrl: control FSM sequencing a radix-2 Booth multiplier datapath
module booth_ctrl
   import booth_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   input  logic q0,
   input  logic qm1,
   output logic CargaM,
   output logic CargaQ,
   output logic ClearA,
   output logic CargaA,
   output logic Resta,
   output logic DesplazaA,
   output logic DesplazaQ,
   output logic busy,
   output logic done
);

   localparam int CW = $clog2(N + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt;
   logic          zero, cnt_ld, cnt_dec, last;

   booth_counter #(.N(N), .CW(CW)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .load (cnt_ld),
      .dec  (cnt_dec),
      .cnt  (cnt),
      .zero (zero)
   );

   // a zero count in SHIFT also ends the run so the counter can never underflow
   assign last = (cnt == CW'(1)) || zero;

   // next state and control decode; abort suppresses every control group
   always_comb begin
      state_d   = state_q;
      CargaM    = 1'b0;
      CargaQ    = 1'b0;
      ClearA    = 1'b0;
      CargaA    = 1'b0;
      Resta     = 1'b0;
      DesplazaA = 1'b0;
      DesplazaQ = 1'b0;
      done      = 1'b0;
      cnt_ld    = 1'b0;
      cnt_dec   = 1'b0;
      busy      = state_q != S_IDLE;
      case (state_q)
         S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
         S_LOAD: begin
            state_d = abort ? S_IDLE : S_EVAL;
            CargaM  = !abort;
            CargaQ  = !abort;
            ClearA  = !abort;
            cnt_ld  = !abort;
         end
         S_EVAL: begin
            state_d = abort ? S_IDLE : S_SHIFT;
            CargaA  = !abort && (q0 ^ qm1);
            Resta   = !abort && q0 && !qm1;
         end
         S_SHIFT: begin
            state_d   = abort ? S_IDLE : last ? S_DONE : S_EVAL;
            DesplazaA = !abort;
            DesplazaQ = !abort;
            cnt_dec   = !abort;
         end
         S_DONE: begin
            state_d = S_IDLE;
            done    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register, forced to IDLE asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: scoreboard bench driving booth_ctrl with a modelled A/Q/M datapath
module tb_booth_ctrl;

   logic clk = 1'b0;
   logic reset, start, abort, q0, qm1;
   logic CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, busy, done;

   booth_ctrl #(.N(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .q0(q0), .qm1(qm1),
      .CargaM(CargaM), .CargaQ(CargaQ), .ClearA(ClearA), .CargaA(CargaA), .Resta(Resta),
      .DesplazaA(DesplazaA), .DesplazaQ(DesplazaQ), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] prod;
      logic [7:0] dec;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_count = 0;

   logic [3:0] m_in, q_in, a_r, q_r, m_r;
   logic       qm1_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // datapath model: M, Q, A, Q(-1) reacting to the controller's strobes
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (CargaM) m_r <= m_in;
      if (CargaQ) q_r <= q_in;
      if (ClearA) begin
         a_r   <= 4'd0;
         qm1_r <= 1'b0;
      end
      if (CargaA) a_r <= Resta ? a_r - m_r : a_r + m_r;
      if (DesplazaA && DesplazaQ) {a_r, q_r, qm1_r} <= {a_r[3], a_r, q_r};
   end

   assign q0  = q_r[0];
   assign qm1 = qm1_r;

   // monitor: follows each operation and checks it against the scoreboard on done
   logic       busy_d1 = 1'b0, done_d1 = 1'b0, bad = 1'b0;
   logic [1:0] pend = 2'd0;
   logic [7:0] dec_log = 8'd0;
   int         load_cyc = 0, shifts = 0;
   exp_t       e;

   always @(negedge clk) begin
      if (!reset) begin
         busy_d1 = 1'b0;
         done_d1 = 1'b0;
      end else begin
         if (busy && !busy_d1) begin
            load_cyc = cyc;
            dec_log  = 8'd0;
            shifts   = 0;
            bad      = 1'b0;
            pend     = 2'd0;
         end
         if (CargaA && (DesplazaA || DesplazaQ || CargaM)) bad = 1'b1;
         if (DesplazaA != DesplazaQ) bad = 1'b1;
         if (CargaA) pend = Resta ? 2'd2 : 2'd1;
         if (DesplazaA) begin
            dec_log = {dec_log[5:0], pend};
            pend    = 2'd0;
            shifts++;
         end
         if (done_d1) chk("idle_after_done", {30'd0, busy, done}, 32'd0);
         if (done) begin
            done_count++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("product", {24'd0, a_r, q_r}, {24'd0, e.prod});
               chk("decisions", {24'd0, dec_log}, {24'd0, e.dec});
               chk("latency", cyc - load_cyc + 1, 32'd10);
               chk("shift_count", shifts, 32'd4);
               chk("group_overlap", {31'd0, bad}, 32'd0);
            end
         end
         busy_d1 = busy;
         done_d1 = done;
      end
   end

   task automatic wait_done(input int tgt);
      for (int i = 0; i < 60 && done_count < tgt; i++) @(negedge clk);
      chk("done_timeout", {31'd0, done_count >= tgt}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                         input logic [7:0] prod, input logic [7:0] dec);
      int tgt;
      exp_q.push_back('{prod, dec});
      tgt = done_count + 1;
      @(negedge clk);
      m_in  = m;
      q_in  = q;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(tgt);
   endtask

   int saved;

   initial begin
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      m_in  = 4'd0;
      q_in  = 4'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {23'd0, CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, busy, done}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // decisions packed oldest first, 2 bits each: 0 none, 1 add, 2 sub
      run_op(4'd3, 4'b0010, 8'h06, 8'h24);
      run_op(4'd3, 4'b0000, 8'h00, 8'h00);
      run_op(4'b0111, 4'b1000, 8'hC8, 8'h02);

      // start held for 25 sampling edges: IDLE samples it at edges 0, 11 and 22
      for (int i = 0; i < 3; i++) exp_q.push_back('{8'h06, 8'h24});
      saved = done_count + 3;
      @(negedge clk);
      m_in  = 4'd3;
      q_in  = 4'b0010;
      start = 1'b1;
      repeat (25) @(negedge clk);
      start = 1'b0;
      wait_done(saved);
      repeat (12) @(negedge clk);
      chk("b2b_done_count", done_count, saved);

      // reset during the SHIFT of iteration 2 (cycle 5)
      saved = done_count;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("shift_iter2", {31'd0, DesplazaA}, 32'd1);
      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", {23'd0, CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, busy, done}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {31'd0, busy}, 32'd0);
      repeat (12) @(negedge clk);
      chk("reset_no_done", done_count, saved);
      run_op(4'd3, 4'b0010, 8'h06, 8'h24);

      // abort in the EVAL of iteration 3 (cycle 6), which would otherwise add
      saved = done_count;
      @(negedge clk);
      m_in  = 4'd3;
      q_in  = 4'b0010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      abort = 1'b1;
      #1 chk("abort_controls", {24'd0, CargaM, CargaQ, ClearA, CargaA, Resta, DesplazaA, DesplazaQ, done}, 32'd0);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {31'd0, busy}, 32'd0);
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_count, saved);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 SHALL have parameter: N, 4, operand width in bits (N >= 2); iteration count.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port: q0  input  1  LSB of multiplier register Q.
REQ-007 SHALL have port: qm1  input  1  Booth extra bit Q(-1).
REQ-008 SHALL have port: CargaM  output  1  load multiplicand register M.
REQ-009 SHALL have port: CargaQ  output  1  load multiplier register Q.
REQ-010 SHALL have port: ClearA  output  1  clear accumulator A and Q(-1).
REQ-011 SHALL have port: CargaA  output  1  load A from adder/subtractor result.
REQ-012 SHALL have port: Resta  output  1  adder mode: 1 = A-M, 0 = A+M; meaningful only with CargaA.
REQ-013 SHALL have port: DesplazaA  output  1  arithmetic shift right of A.
REQ-014 SHALL have port: DesplazaQ  output  1  shift right of Q (A[0] into Q MSB, Q[0] into Q(-1)).
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port: done  output  1  one-cycle pulse on completion.

Function
REQ-017 SHALL implement states IDLE, LOAD, EVAL, SHIFT, DONE.
REQ-018 SHALL, in IDLE, go to LOAD on start=1, else stay; all outputs except nothing low.
REQ-019 SHALL, in LOAD (1 cycle), assert CargaM, CargaQ, ClearA; set iteration counter to N; go to EVAL.
REQ-020 SHALL, in EVAL, assert CargaA when q0 XOR qm1 = 1, with Resta = q0 (10 -> subtract, 01 -> add); no CargaA for 00/11; always go to SHIFT.
REQ-021 SHALL, in SHIFT, assert DesplazaA and DesplazaQ together, decrement counter; go to DONE when counter was 1, else EVAL.
REQ-022 SHALL, in DONE, assert done for exactly one cycle and return to IDLE; start in DONE ignored.
REQ-023 SHALL have fixed latency: done high in the (2N+2)th cycle after the edge sampling start (10 cycles for N=4).
REQ-024 SHALL never assert CargaA and DesplazaA in the same cycle; at most one of LOAD/EVAL/SHIFT control groups active per cycle.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort=1 in LOAD/EVAL/SHIFT, drive no control outputs that cycle and return to IDLE next edge without pulsing done; abort in IDLE/DONE has no effect.
REQ-027 SHALL size the counter as $clog2(N+1) bits; counter never wraps below 0.
REQ-028 SHALL decode all outputs from state (Moore) except CargaA/Resta, which depend on q0/qm1 in EVAL.
REQ-029 SHALL force unused/illegal state encodings to IDLE on the next edge.

Reset
REQ-030 SHALL, while reset=0, immediately force state IDLE, counter 0, and all outputs 0, regardless of clock.
REQ-031 SHALL, after reset release mid-operation, require a fresh start; no done pulse for the interrupted operation.

Structure
REQ-032 SHALL place state encoding typedef and default width N=4 in shared package booth_pkg.
REQ-033 SHALL implement the iteration counter as one sub-module booth_counter (load N, decrement, zero flag).

Verification (N=4, bench models A/Q/M datapath)
REQ-034 SHALL check M=3, Q=0010: EVAL decisions none, sub, add, none; done in cycle 10; product 8'h06.
REQ-035 SHALL check Q=0000: CargaA never asserted, four DesplazaA/DesplazaQ pulses, done in cycle 10, product 0.
REQ-036 SHALL check M=0111, Q=1000: only iteration 4 subtracts; product 8'hC8 (-56).
REQ-037 SHALL check start held high for 25 cycles: back-to-back operations, each done pulse 1 cycle, one IDLE cycle between; start pulses while busy cause no restart.
REQ-038 SHALL check reset=0 asserted mid-SHIFT of iteration 2: outputs 0 at once without clock edge, IDLE after release, next start completes normally.
REQ-039 SHALL check abort=1 during EVAL of iteration 3: no control outputs that cycle, busy=0 next cycle, done never asserted.
